// File: rtl/flow_rule_loader_if.sv
// flow_rule_loader_if: rule request handshake plus the flow table write port
interface flow_rule_loader_if;
    logic         rule_valid;
    logic         rule_ready;
    logic [7:0]   rule_index;
    logic [127:0] rule_key;
    logic [15:0]  rule_id;
    logic         rule_enable;
    logic         we;
    logic [7:0]   waddr;
    logic [31:0]  wdata;
    logic         wdone;

    modport master (
        input  rule_valid, rule_index, rule_key, rule_id, rule_enable, wdone,
        output rule_ready, we, waddr, wdata
    );

    modport slave (
        output rule_valid, rule_index, rule_key, rule_id, rule_enable, wdone,
        input  rule_ready, we, waddr, wdata
    );
endinterface

// File: rtl/flow_rule_loader.sv
// flow_rule_loader: serialises flow rules (or a full-table clear) into 5-beat table writes
module flow_rule_loader #(
    parameter int WDONE_TIMEOUT = 16,
    parameter int TABLE_DEPTH   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    flow_rule_loader_if.master bus,
    input  logic               clear_req,
    input  logic               err_clr,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic [15:0]        rules_written
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;
    localparam int TW = $clog2(WDONE_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(WDONE_TIMEOUT - 1);
    localparam logic [7:0] LAST_ADDR = 8'(TABLE_DEPTH - 1);

    logic [1:0]    state;
    logic [2:0]    beat;
    logic [TW-1:0] wait_cnt;
    logic          clearing;
    logic [7:0]    index;
    logic [127:0]  key;
    logic [15:0]   id;
    logic          enable;
    logic          start_clear;
    logic          accept;
    logic          timeout;

    // A clear reuses the captured-rule registers: zero key/word4, index walks the table
    assign start_clear    = state == IDLE && clear_req && !err_timeout;
    assign bus.rule_ready = rst_n && state == IDLE && !err_timeout && !clear_req;
    assign accept         = bus.rule_valid && bus.rule_ready;
    assign timeout        = state == WAIT && !bus.wdone && wait_cnt == TO_LAST;
    assign bus.we         = state == ISSUE;
    assign bus.waddr      = index;
    assign bus.wdata      = beat == 3'd0 ? key[31:0]  :
                            beat == 3'd1 ? key[63:32] :
                            beat == 3'd2 ? key[95:64] :
                            beat == 3'd3 ? key[127:96] : {15'b0, enable, id};
    assign busy           = state != IDLE;
    assign done           = state == FIN;

    // Sequencer: capture a request, issue each beat, wait for its wdone, complete or abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat          <= '0;
            wait_cnt      <= '0;
            clearing      <= 1'b0;
            index         <= '0;
            key           <= '0;
            id            <= '0;
            enable        <= 1'b0;
            rules_written <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_clear) begin
                        clearing <= 1'b1;
                        index    <= '0;
                        key      <= '0;
                        id       <= '0;
                        enable   <= 1'b0;
                        beat     <= '0;
                        state    <= ISSUE;
                    end else if (accept) begin
                        index  <= bus.rule_index;
                        key    <= bus.rule_key;
                        id     <= bus.rule_id;
                        enable <= bus.rule_enable;
                        beat   <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.wdone) begin
                        if (beat != 3'd4) begin
                            beat  <= beat + 3'd1;
                            state <= ISSUE;
                        end else if (clearing && index != LAST_ADDR) begin
                            index <= index + 8'd1;
                            beat  <= '0;
                            state <= ISSUE;
                        end else begin
                            state <= FIN;
                        end
                    end else if (timeout) begin
                        clearing <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: begin
                    if (!clearing) rules_written <= rules_written + 16'd1;
                    clearing <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as err_clr keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_timeout <= 1'b0;
        else        err_timeout <= timeout ? 1'b1 : err_clr ? 1'b0 : err_timeout;
    end
endmodule

// File: tb/tb_flow_rule_loader.sv
// tb_flow_rule_loader: directed tests against a beat-queue model of the loader
module tb_flow_rule_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        err_clr = 1'b0;
    logic        busy, done, err_timeout;
    logic [15:0] rules_written;

    flow_rule_loader_if fif();

    flow_rule_loader dut (
        .clk(clk), .rst_n(rst_n), .bus(fif), .clear_req(clear_req), .err_clr(err_clr),
        .busy(busy), .done(done), .err_timeout(err_timeout), .rules_written(rules_written)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic [39:0] exp_q[$];
    int          op_beats[$];
    bit          op_rule[$];
    int          beats_seen = 0;
    logic [15:0] model_rw = '0;
    int          we_cyc[$];
    int          done_cyc = -1, done_cnt = 0;
    logic [39:0] e;
    int          dly = 1, acks_left = -1, pend = 0, last_ack_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_rule(input logic [7:0] idx, input logic [127:0] key,
                                      input logic [15:0] id, input logic en);
        for (int i = 0; i < 4; i++) exp_q.push_back({idx, key[32*i +: 32]});
        exp_q.push_back({idx, 15'b0, en, id});
        op_beats.push_back(5);
        op_rule.push_back(1'b1);
    endfunction

    function automatic void push_clear();
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 5; b++) exp_q.push_back({8'(a), 32'h0});
        op_beats.push_back(1280);
        op_rule.push_back(1'b0);
    endfunction

    function automatic void flush_model();
        exp_q.delete();
        op_beats.delete();
        op_rule.delete();
        beats_seen = 0;
    endfunction

    // Compare every write beat and completion against the model
    always @(negedge clk) if (rst_n) begin
        chk("rules_written", rules_written, model_rw);
        if (fif.we) begin
            we_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_we: addr %0h data %0h with no beat expected", fif.waddr, fif.wdata);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", fif.waddr, e[39:32]);
                chk("wdata", fif.wdata, e[31:0]);
                beats_seen++;
            end
        end
        if (done) begin
            done_cyc = cyc;
            done_cnt++;
            if (op_beats.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done at cycle %0d with no operation pending", cyc);
            end else begin
                chk("beats_per_op", beats_seen, op_beats.pop_front());
                if (op_rule.pop_front()) model_rw++;
            end
            beats_seen = 0;
        end
    end

    // Table responder: wdone dly cycles after each we, optionally stops acking
    initial begin
        fif.wdone = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fif.wdone = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0 && acks_left != 0) begin
                    fif.wdone = 1'b1;
                    last_ack_cyc = cyc;
                    if (acks_left > 0) acks_left--;
                end
            end
            if (fif.we) pend = dly;
        end
    end

    task automatic submit(input logic [7:0] idx, input logic [127:0] key, input logic [15:0] id,
                          input logic en, output int acc);
        int n = 0;
        fif.rule_index = idx;
        fif.rule_key = key;
        fif.rule_id = id;
        fif.rule_enable = en;
        fif.rule_valid = 1'b1;
        @(negedge clk);
        while (!fif.rule_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!fif.rule_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: rule_ready still 0 after %0d cycles", n);
        end else begin
            push_rule(idx, key, id, en);
        end
        @(posedge clk);
        #1 fif.rule_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #1;
            if (done_cnt > start) return;
        end
        checks++;
        errors++;
        $display("FAIL done_wait: no done within %0d cycles", budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, c0, n, ec;
        fif.rule_valid = 1'b0;
        fif.rule_index = '0;
        fif.rule_key = '0;
        fif.rule_id = '0;
        fif.rule_enable = 1'b0;
        #1;
        chk("reset_rule_ready", fif.rule_ready, 0);
        chk("reset_we", fif.we, 0);
        chk("reset_waddr", fif.waddr, 0);
        chk("reset_wdata", fif.wdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err_timeout, 0);
        chk("reset_rules_written", rules_written, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("ready_after_reset", fif.rule_ready, 1);

        // Single rule, wdone one cycle after each we
        @(posedge clk);
        #1 we_cyc.delete();
        submit(8'h3C, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'h0102, 1'b1, a);
        chk("model_beat0", exp_q[0], {8'h3C, 32'hCCDDEEFF});
        chk("model_beat3", exp_q[3], {8'h3C, 32'h00112233});
        chk("model_beat4", exp_q[4], {8'h3C, 32'h00010102});
        chk("busy_in_rule", busy, 1);
        wait_done(50);
        chk("we_count", we_cyc.size(), 5);
        for (int i = 0; i < 5 && i < we_cyc.size(); i++) chk("we_cycle", we_cyc[i], a + 1 + 2 * i);
        chk("done_cycle", done_cyc, a + 11);
        chk("ready_cycle", cyc, a + 12);
        chk("ready_after_rule", fif.rule_ready, 1);
        chk("rw_after_rule", rules_written, 1);

        // Slow table: wdone three cycles after each we
        dly = 3;
        we_cyc.delete();
        submit(8'hA5, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 16'hBEEF, 1'b0, a);
        chk("model_beat4_slow", exp_q[4], {8'hA5, 32'h0000BEEF});
        wait_done(100);
        chk("we_count_slow", we_cyc.size(), 5);
        chk("we_spacing_slow", we_cyc[1] - we_cyc[0], 4);
        chk("done_after_ack", done_cyc, last_ack_cyc + 1);
        chk("done_cycle_slow", done_cyc, a + 21);
        chk("rw_after_slow", rules_written, 2);
        dly = 1;

        // Clear and rule requested together: clear wins, rule follows
        we_cyc.delete();
        c0 = done_cnt;
        fif.rule_index = 8'h07;
        fif.rule_key = 128'h7;
        fif.rule_id = 16'h0007;
        fif.rule_enable = 1'b1;
        fif.rule_valid = 1'b1;
        clear_req = 1'b1;
        @(negedge clk);
        chk("ready_during_clear_req", fif.rule_ready, 0);
        push_clear();
        a = cyc;
        @(posedge clk);
        #1 clear_req = 1'b0;
        submit(8'h07, 128'h7, 16'h0007, 1'b1, n);
        chk("clear_we_count", we_cyc.size(), 1280);
        chk("clear_done_cycle", done_cyc, a + 2561);
        chk("clear_done_count", done_cnt - c0, 1);
        chk("rule_after_clear_accept", n, a + 2562);
        chk("rw_after_clear", rules_written, 2);
        wait_done(50);
        chk("rw_after_clear_rule", rules_written, 3);

        // Table stops acking after beat 2: timeout abort
        acks_left = 3;
        we_cyc.delete();
        c0 = done_cnt;
        submit(8'h55, 128'h1, 16'h1234, 1'b1, a);
        n = 0;
        while (!err_timeout && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        ec = cyc;
        chk("timeout_we_count", we_cyc.size(), 4);
        chk("timeout_cycle", ec, a + 24);
        chk("timeout_err", err_timeout, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_ready", fif.rule_ready, 0);
        chk("timeout_no_done", done_cnt - c0, 0);
        chk("timeout_rw", rules_written, 3);
        flush_model();
        acks_left = -1;
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        chk("err_cleared", err_timeout, 0);
        chk("ready_after_err_clr", fif.rule_ready, 1);

        // rules_written wraps from FFFF to 0000
        model_rw = 16'hFFFF;
        force dut.rules_written = 16'hFFFF;
        @(posedge clk);
        #1 release dut.rules_written;
        chk("rw_preset", rules_written, 16'hFFFF);
        submit(8'h01, 128'h2, 16'h0002, 1'b1, a);
        wait_done(50);
        chk("rw_wrap", rules_written, 16'h0000);

        // Reset during beat 3, then a clean rule
        we_cyc.delete();
        submit(8'h99, 128'h3, 16'h4242, 1'b1, a);
        n = 0;
        while (!(fif.we && we_cyc.size() == 3) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reset_point_cycle", cyc, a + 7);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_we", fif.we, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_err", err_timeout, 0);
        chk("midreset_ready", fif.rule_ready, 0);
        chk("midreset_rw", rules_written, 0);
        flush_model();
        model_rw = '0;
        pend = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 we_cyc.delete();
        submit(8'hC3, 128'hFFFFFFFF_00000000_AAAAAAAA_55555555, 16'hFFFF, 1'b1, a);
        wait_done(50);
        chk("post_reset_done_cycle", done_cyc, a + 11);
        chk("post_reset_we_count", we_cyc.size(), 5);
        chk("post_reset_rw", rules_written, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
